rr_grant_sched: RTL and testbench
=================================

RR_GRANT_SCHED -- requirements
Module: rr_grant_sched

Interface
REQ-001 Parameter WIDTH, default 4: number of requesters; legal range 2..32.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive cycles one owner keeps a grant; legal range >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  WIDTH  level request per requester; bit i = requester i.
REQ-006 gnt  output  WIDTH  registered one-hot grant.
REQ-007 gnt_idx  output  $clog2(WIDTH)  registered binary index of the set gnt bit.
REQ-008 gnt_valid  output  1  registered; equals OR of gnt.
REQ-009 hold_timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-010 Two states SHALL exist: IDLE (no owner) and BUSY (one owner, gnt non-zero).
REQ-011 Priority pointer ptr SHALL select the first requester at or after ptr, searching upward with wrap from WIDTH-1 to 0.
REQ-012 IDLE with req==0 SHALL remain IDLE with gnt=0.
REQ-013 IDLE with req!=0 at an edge SHALL, at that edge, set gnt to the selected bit, gnt_idx to its index, gnt_valid=1, enter BUSY (latency 1 cycle from req sampled to gnt).
REQ-014 On every new grant, ptr SHALL become winner+1 modulo WIDTH and hold counter cnt SHALL become 0.
REQ-015 BUSY: cnt SHALL increment each edge the owner keeps gnt; owner keeps gnt while req[owner]=1 and cnt < MAX_HOLD-1.
REQ-016 Release SHALL occur at the edge where req[owner]=0, or where cnt==MAX_HOLD-1 (forced release); so gnt lasts at most MAX_HOLD cycles.
REQ-017 On release, if any req bit is 1 at that edge, a new grant per REQ-011/013/014 SHALL be issued at the same edge (back-to-back, no idle cycle); else gnt=0, gnt_idx=0, gnt_valid=0, IDLE.
REQ-018 Because ptr=owner+1, a released owner still requesting SHALL win only if no other requester is active; then gnt stays asserted continuously with cnt restarted.
REQ-019 hold_timeout SHALL be 1 for exactly the cycle after a forced release edge, 0 otherwise; a voluntary release (req[owner]=0) SHALL not pulse it.
REQ-020 gnt SHALL never have more than one bit set; a gnt bit SHALL only be set if its req bit was 1 at the granting edge.
REQ-021 gnt_idx SHALL always equal the binary encoding of gnt, and 0 when gnt=0.
REQ-022 Requests from non-owners SHALL not affect an active grant before release.
REQ-023 MAX_HOLD=1 SHALL re-arbitrate every cycle (pure round-robin per cycle).

Reset
REQ-024 rst_n low SHALL immediately, independent of clk, force gnt=0, gnt_idx=0, gnt_valid=0, hold_timeout=0, ptr=0, cnt=0, state IDLE.
REQ-025 Reset asserted mid-grant SHALL abandon the grant; after rst_n rises, first arbitration starts from ptr=0.
REQ-026 Outputs SHALL be stable at reset values until the first rising clk edge after rst_n deasserts.

Verification (WIDTH=4, MAX_HOLD=4)
REQ-027 After reset, req=4'b0100 for one edge -> next cycle gnt=4'b0100, gnt_idx=2, gnt_valid=1, hold_timeout=0.
REQ-028 req=4'b1111, each owner drops its req 2 cycles after grant and re-raises next cycle -> grant order idx 0,1,2,3,0 with no idle cycle between grants.
REQ-029 req=4'b0010 held 10 cycles -> gnt=4'b0010 continuous, hold_timeout pulses after cycles 4 and 8, gnt_valid never drops.
REQ-030 Owner idx 1 holds, req[3] raised after 1 cycle, owner never drops -> gnt moves to 4'b1000 after 4 grant cycles, hold_timeout=1 that cycle.
REQ-031 Grant to idx 3, then req=4'b1001 -> next winner idx 0 (wrap), ptr=1 afterwards.
REQ-032 rst_n pulsed low mid-grant between clk edges -> gnt=0, gnt_valid=0 immediately; req=4'b1100 after release -> first grant idx 2.

Source files
------------

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler with a bounded hold time per owner.
// A single owner keeps its grant while it keeps requesting, up to MAX_HOLD
// consecutive cycles. Releases re-arbitrate in the same edge so that grants
// can run back-to-back. The search starts one slot after the last winner.
module rr_grant_sched #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic                     gnt_valid,
    output logic                     hold_timeout
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW:0]   WIDTH_W  = (IW + 1)'(WIDTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW:0]     sum;
    logic [IW-1:0]   cand;
    logic [WIDTH-1:0] sel_onehot;
    logic [IW-1:0]   sel_next_ptr;

    logic            owner_req;
    logic            at_limit;
    logic            keep;
    logic            forced;
    logic            do_grant;
    logic            go_idle;

    // First active requester at or after ptr, wrapping from WIDTH-1 to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= WIDTH_W) begin
                sum = sum - WIDTH_W;
            end
            cand = sum[IW-1:0];
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // One-hot form of the winner and the pointer value that follows it.
    always_comb begin
        sel_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << sel_idx;
        sel_next_ptr = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
    end

    // Hold/release decision for the current owner. gnt_idx is the owner
    // whenever BUSY; its value in IDLE is irrelevant because these terms
    // are qualified with the state below.
    always_comb begin
        owner_req = req[gnt_idx];
        at_limit  = (cnt == CNT_LAST);
        keep      = (state == BUSY) && owner_req && !at_limit;
        forced    = (state == BUSY) && owner_req && at_limit;
        do_grant  = sel_found && !keep;
        go_idle   = (state == BUSY) && !keep && !sel_found;
    end

    // Grant FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            gnt          <= '0;
            gnt_idx      <= '0;
            gnt_valid    <= 1'b0;
            hold_timeout <= 1'b0;
        end else begin
            hold_timeout <= forced;
            if (do_grant) begin
                state     <= BUSY;
                gnt       <= sel_onehot;
                gnt_idx   <= sel_idx;
                gnt_valid <= 1'b1;
                ptr       <= sel_next_ptr;
                cnt       <= '0;
            end else if (go_idle) begin
                state     <= IDLE;
                gnt       <= '0;
                gnt_idx   <= '0;
                gnt_valid <= 1'b0;
                cnt       <= '0;
            end else if (keep) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Randomized scoreboard bench for rr_grant_sched (WIDTH=4, MAX_HOLD=4).
// The reference model tracks owner, cycles held and the next search start.
module tb_rr_grant_sched;

    localparam int W  = 4;
    localparam int MH = 4;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       hold_timeout;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    rr_grant_sched #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .gnt_valid    (gnt_valid),
        .hold_timeout (hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
    endtask

    // One clock edge of the scheduling rules applied to sampled request r.
    task automatic model_step(input logic [3:0] r, output exp_t e);
        logic to;
        to = 1'b0;
        if (m_owner >= 0) begin
            if (r[m_owner] && m_held < MH) begin
                m_held++;
            end else begin
                to      = r[m_owner];
                m_owner = -1;
            end
        end
        if (m_owner < 0) begin
            for (int k = 0; k < W; k++) begin
                int c;
                c = (m_ptr + k) % W;
                if (r[c]) begin
                    m_owner = c;
                    m_held  = 1;
                    m_ptr   = (c + 1) % W;
                    break;
                end
            end
        end
        e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.idx   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.valid = (m_owner >= 0);
        e.to    = to;
    endtask

    task automatic cycle(input logic [3:0] r);
        exp_t e;
        req = r;
        @(posedge clk);
        model_step(r, e);
        q.push_back(e);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'd0);
        chk({tag, "_idx"},   32'(gnt_idx), 32'd0);
        chk({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_to"},    32'(hold_timeout), 32'd0);
    endtask

    // Reset pulse placed between clock edges, outputs checked right away.
    task automatic mid_reset(input logic [3:0] r_during);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        req = r_during;
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents registered outputs.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("gnt",          32'(gnt),          32'(e.gnt));
            chk("gnt_idx",      32'(gnt_idx),      32'(e.idx));
            chk("gnt_valid",    32'(gnt_valid),    32'(e.valid));
            chk("hold_timeout", 32'(hold_timeout), 32'(e.to));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        check_reset_vals("por_held");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();

        // Single requester, one edge.
        cycle(4'b0100);
        cycle(4'b0000);
        cycle(4'b0000);

        // All requesting; each owner drops after two grant cycles.
        for (int i = 0; i < 12; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
            cycle(r);
        end
        cycle(4'b0000);

        // Lone requester held: forced releases with continuous grant.
        for (int i = 0; i < 10; i++) cycle(4'b0010);
        cycle(4'b0000);

        // Owner 1 never drops, requester 3 joins.
        cycle(4'b0010);
        for (int i = 0; i < 6; i++) cycle(4'b1010);
        cycle(4'b0000);

        // Wrap from index 3 to index 0.
        mid_reset(4'b0000);
        cycle(4'b1000);
        for (int i = 0; i < 6; i++) cycle(4'b1001);
        cycle(4'b0000);

        // Reset mid-grant, then first arbitration from ptr 0.
        cycle(4'b0010);
        cycle(4'b0010);
        mid_reset(4'b0010);
        cycle(4'b1100);
        cycle(4'b1100);
        cycle(4'b0000);

        // Randomized traffic with occasional resets.
        r = 4'b0000;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 7) == 0) begin
                r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
            end
            if (i == 150 || i == 330) begin
                mid_reset(r);
            end
            cycle(r);
        end
        cycle(4'b0000);

        @(negedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
